// File: rtl/mem_boot_loader_pkg.sv
// Shared constants and types for the start-up memory boot loader.
// Command/response bytes of the UART load protocol, FSM state and bus mode.
package mem_boot_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } boot_state_e;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_RUN  = 1'b1
  } boot_mode_e;

  // Modulo-256 running checksum over data bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/mem_boot_loader_bus_mux.sv
// LOAD/RUN selection of the shared memory bus; RUN is a zero-latency pass-through.
module boot_bus_mux
  import mem_boot_loader_pkg::*;
(
  input  logic        mode_run,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_write,
  input  logic [3:0]  cpu_mem_wmask,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_wgrubby,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wgrubby
);

  // Select bus owner: core in RUN, loader write registers in LOAD.
  always_comb begin
    mem_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = 4'b0000;
    mem_wdata   = 32'h0000_0000;
    mem_addr    = 32'h0000_0000;
    mem_wgrubby = 1'b0;
    if (mode_run) begin
      mem_valid   = cpu_mem_valid;
      mem_write   = cpu_mem_write;
      mem_wmask   = cpu_mem_wmask;
      mem_wdata   = cpu_mem_wdata;
      mem_addr    = cpu_mem_addr;
      mem_wgrubby = cpu_mem_wgrubby;
    end else begin
      mem_valid   = load_valid;
      mem_write   = load_valid;
      mem_wmask   = 4'b1111;
      mem_wdata   = load_wdata;
      mem_addr    = load_addr;
      mem_wgrubby = 1'b0;
    end
  end

endmodule

// File: rtl/mem_boot_loader.sv
// Start-up boot loader: writes a UART byte-stream image into memory while the
// core is held in reset, then hands the memory bus to the core on command.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1_000_000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        cpu_rstn,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_write,
  input  logic [3:0]  cpu_mem_wmask,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_wgrubby,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wgrubby,
  output logic        load_error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  boot_state_e   state_r, state_s;
  boot_mode_e    mode_r, mode_s;
  logic          cpu_rstn_r, cpu_rstn_s;
  logic          tx_valid_r, tx_valid_s;
  logic [7:0]    tx_data_r, tx_data_s;
  logic          load_error_r, load_error_s;
  logic [1:0]    byte_cnt_r, byte_cnt_s;
  logic [31:0]   addr_r, addr_s;
  logic [15:0]   word_cnt_r, word_cnt_s;
  logic [31:0]   word_r, word_s;
  logic [7:0]    csum_r, csum_s;
  logic          wr_valid_r, wr_valid_s;
  logic [31:0]   wr_addr_r, wr_addr_s;
  logic [31:0]   wr_data_r, wr_data_s;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;

  // Frame decode, write-pulse generation and inter-byte timeout.
  always_comb begin
    state_s      = state_r;
    mode_s       = mode_r;
    cpu_rstn_s   = cpu_rstn_r;
    tx_valid_s   = 1'b0;
    tx_data_s    = tx_data_r;
    load_error_s = load_error_r;
    byte_cnt_s   = byte_cnt_r;
    addr_s       = addr_r;
    word_cnt_s   = word_cnt_r;
    word_s       = word_r;
    csum_s       = csum_r;
    wr_valid_s   = 1'b0;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    if (rx_valid || (state_r == ST_IDLE)) begin
      tmo_cnt_s = '0;
    end else begin
      tmo_cnt_s = tmo_cnt_r + TW'(1);
    end

    if (rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          // Only 'R' is honoured once the core is running.
          if (rx_data == CMD_RESET) begin
            cpu_rstn_s = 1'b0;
            mode_s     = MODE_LOAD;
            tx_valid_s = 1'b1;
            tx_data_s  = RSP_OK;
          end else if ((mode_r == MODE_LOAD) && (rx_data == CMD_WRITE)) begin
            state_s      = ST_ADDR;
            byte_cnt_s   = 2'd0;
            csum_s       = 8'h00;
            word_s       = 32'h0000_0000;
            load_error_s = 1'b0;
          end else if ((mode_r == MODE_LOAD) && (rx_data == CMD_GO)) begin
            cpu_rstn_s = 1'b1;
            mode_s     = MODE_RUN;
            tx_valid_s = 1'b1;
            tx_data_s  = RSP_OK;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ADDR: begin
          addr_s     = {rx_data, addr_r[31:8]};
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            addr_s  = {rx_data, addr_r[31:8]} & ADDR_MASK;
            state_s = ST_LEN;
          end else begin
            state_s = ST_ADDR;
          end
        end
        ST_LEN: begin
          if (byte_cnt_r[0] == 1'b0) begin
            word_cnt_s = {8'h00, rx_data};
            byte_cnt_s = 2'd1;
          end else begin
            word_cnt_s = {rx_data, word_cnt_r[7:0]};
            byte_cnt_s = 2'd0;
            if ({rx_data, word_cnt_r[7:0]} == 16'd0) begin
              state_s = ST_CSUM;
            end else begin
              state_s = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          word_s     = {rx_data, word_r[31:8]};
          csum_s     = csum_add(csum_r, rx_data);
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            wr_valid_s = 1'b1;
            wr_addr_s  = addr_r;
            wr_data_s  = {rx_data, word_r[31:8]};
            addr_s     = addr_r + 32'd4;
            word_cnt_s = word_cnt_r - 16'd1;
            if (word_cnt_r == 16'd1) begin
              state_s = ST_CSUM;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_CSUM: begin
          state_s    = ST_IDLE;
          tx_valid_s = 1'b1;
          if (rx_data == csum_r) begin
            tx_data_s = RSP_OK;
          end else begin
            tx_data_s    = RSP_ERR;
            load_error_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if ((state_r != ST_IDLE) && (tmo_cnt_r == TMO_LAST)) begin
      // Stalled frame: abort and drop any partially assembled word.
      state_s      = ST_IDLE;
      tx_valid_s   = 1'b1;
      tx_data_s    = RSP_ERR;
      load_error_s = 1'b1;
      byte_cnt_s   = 2'd0;
      word_s       = 32'h0000_0000;
      tmo_cnt_s    = '0;
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      mode_r       <= MODE_LOAD;
      cpu_rstn_r   <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      load_error_r <= 1'b0;
      byte_cnt_r   <= 2'd0;
      addr_r       <= 32'h0000_0000;
      word_cnt_r   <= 16'd0;
      word_r       <= 32'h0000_0000;
      csum_r       <= 8'h00;
      wr_valid_r   <= 1'b0;
      wr_addr_r    <= 32'h0000_0000;
      wr_data_r    <= 32'h0000_0000;
      tmo_cnt_r    <= '0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      cpu_rstn_r   <= cpu_rstn_s;
      tx_valid_r   <= tx_valid_s;
      tx_data_r    <= tx_data_s;
      load_error_r <= load_error_s;
      byte_cnt_r   <= byte_cnt_s;
      addr_r       <= addr_s;
      word_cnt_r   <= word_cnt_s;
      word_r       <= word_s;
      csum_r       <= csum_s;
      wr_valid_r   <= wr_valid_s;
      wr_addr_r    <= wr_addr_s;
      wr_data_r    <= wr_data_s;
      tmo_cnt_r    <= tmo_cnt_s;
    end
  end

  assign tx_valid   = tx_valid_r;
  assign tx_data    = tx_data_r;
  assign cpu_rstn   = cpu_rstn_r;
  assign load_error = load_error_r;

  boot_bus_mux u_bus_mux (
    .mode_run        (mode_r == MODE_RUN),
    .load_valid      (wr_valid_r),
    .load_addr       (wr_addr_r),
    .load_wdata      (wr_data_r),
    .cpu_mem_valid   (cpu_mem_valid),
    .cpu_mem_write   (cpu_mem_write),
    .cpu_mem_wmask   (cpu_mem_wmask),
    .cpu_mem_wdata   (cpu_mem_wdata),
    .cpu_mem_addr    (cpu_mem_addr),
    .cpu_mem_wgrubby (cpu_mem_wgrubby),
    .mem_valid       (mem_valid),
    .mem_write       (mem_write),
    .mem_wmask       (mem_wmask),
    .mem_wdata       (mem_wdata),
    .mem_addr        (mem_addr),
    .mem_wgrubby     (mem_wgrubby)
  );

endmodule
